// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, legal data widths.
package uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP1  = 3'd4;
    localparam uart_state_t ST_STOP2  = 3'd5;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit over a full data word; also reused by the receive-side checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par_type,
    output logic              parity_c
);

    // Even parity makes the total number of ones even; odd inverts that.
    assign parity_c = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start, DATA_W data bits, optional parity, 1 or 2 stops,
// with a one-entry holding register so frames can stream back-to-back.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              par_en,
    input  logic              par_type,
    input  logic              two_stop,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    uart_state_t       state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [DATA_W-1:0] hold_data, hold_nxt;
    logic              ready_nxt;
    logic              par_en_q, par_en_nxt;
    logic              two_stop_q, two_stop_nxt;
    logic              par_bit_q, par_bit_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic              launch, finish;
    logic              parity_c;

    // Shift register always emits bit 0 first, so MSB-first words are reversed on load.
    function automatic logic [DATA_W-1:0] line_order(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        if (LSB_FIRST) r = d;
        else           r = {<<{d}};
        return r;
    endfunction

    // Parity of the held word, sampled together with the rest of the config at launch.
    uart_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data     (hold_data),
        .par_type (par_type),
        .parity_c (parity_c)
    );

    // State and output registers; reset idles the line and empties the holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            hold_data  <= '0;
            data_ready <= 1'b1;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            shreg      <= shreg_nxt;
            hold_data  <= hold_nxt;
            data_ready <= ready_nxt;
            par_en_q   <= par_en_nxt;
            two_stop_q <= two_stop_nxt;
            par_bit_q  <= par_bit_nxt;
            tx_out     <= tx_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state and next-output logic; all line changes are gated by baud_tick.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        hold_nxt     = hold_data;
        ready_nxt    = data_ready;
        par_en_nxt   = par_en_q;
        two_stop_nxt = two_stop_q;
        par_bit_nxt  = par_bit_q;
        tx_nxt       = tx_out;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        launch       = 1'b0;
        finish       = 1'b0;

        // Capture only into an empty holding register; a launch needs a full one,
        // so capture and launch never happen on the same cycle.
        if (data_valid && data_ready) begin
            hold_nxt  = data_in;
            ready_nxt = 1'b0;
        end

        if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    launch = !data_ready;
                end
                ST_START: begin
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                    cnt_nxt   = '0;
                    state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        if (par_en_q) begin
                            state_nxt = ST_PARITY;
                            tx_nxt    = par_bit_q;
                        end else begin
                            state_nxt = ST_STOP1;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        cnt_nxt   = bit_cnt + CNT_W'(1);
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
                ST_PARITY: begin
                    state_nxt = ST_STOP1;
                    tx_nxt    = 1'b1;
                end
                ST_STOP1: begin
                    if (two_stop_q) begin
                        state_nxt = ST_STOP2;
                        tx_nxt    = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
                ST_STOP2: begin
                    finish = 1'b1;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            endcase
        end

        // End of the final stop bit: chain straight into the next frame if one is held.
        if (finish) begin
            done_nxt = 1'b1;
            if (!data_ready) begin
                launch = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        end

        // Launch: move the held word into the shifter and freeze this frame's config.
        if (launch) begin
            shreg_nxt    = line_order(hold_data);
            ready_nxt    = 1'b1;
            par_en_nxt   = par_en;
            two_stop_nxt = two_stop;
            par_bit_nxt  = parity_c;
            cnt_nxt      = '0;
            state_nxt    = ST_START;
            tx_nxt       = 1'b0;
            busy_nxt     = 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
Parametrised UART transmit frame generator. It replaces a fixed 4-way line mux with a complete framing engine: start bit, DATA_W data bits, optional even/odd parity, then 1 or 2 stop bits.
It accepts words through a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle gap.
It sits between the TX FIFO/host interface and the serial pin, and is paced by an external baud-rate tick.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = MSB sent first.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk pulse per bit period; all line changes occur only on cycles with baud_tick=1
par_en  input  1  1 = parity bit inserted after data
par_type  input  1  0 = even, 1 = odd
two_stop  input  1  1 = two stop bits, 0 = one
data_valid  input  1  word offered
data_in  input  DATA_W  word to send
data_ready  output  1  holding register empty; transfer occurs when data_valid & data_ready
tx_out  output  1  serial line, registered, idle high
busy  output  1  high from START entry until the tick ending the final stop bit
frame_done  output  1  one-clk pulse on the tick that ends the final stop bit

Behaviour:
- Reset (asynchronous, rst=0):
  - tx_out=1, busy=0, data_ready=1, frame_done=0.
  - State IDLE; holding register empty; bit counter 0.
  - Reset asserted mid-frame drives the line high immediately; the partial frame is abandoned and nothing resumes after release.
- Handshake:
  - data_ready = !hold_valid. On valid&ready, data_in is captured and hold_valid=1; data_ready falls the next cycle.
  - data_ready is never a function of data_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Transitions happen only on baud_tick.
- IDLE:
  - If hold_valid & baud_tick: load shift register from hold, clear hold_valid, latch par_en/par_type/two_stop, compute parity over all DATA_W bits, enter START with tx_out<=0 and busy<=1.
  - A word captured on the same cycle as a tick is not launched until the next tick.
- START → DATA on tick: tx_out <= first data bit; counter=0.
- DATA:
  - Each tick advances the counter and outputs the next bit.
  - After the bit with counter=DATA_W-1 has been held one period, go to PARITY if the latched par_en is set, else to STOP1.
- PARITY:
  - tx_out = XOR of the data bits, inverted when par_type=1.
  - Even parity means total count of ones (data+parity) is even.
- STOP1: tx_out=1. On tick, go to STOP2 if two_stop is latched, else finish.
- STOP2: tx_out=1. On tick, finish.
- Finish tick:
  - frame_done=1 for that cycle.
  - If hold_valid: go directly to START (tx_out<=0) with new config latched; busy stays 1.
  - Else: go to IDLE with tx_out=1 and busy<=0.
- Every bit is held exactly one baud period. Config changes mid-frame have no effect on the frame in flight.
- A capture on the same cycle as the finish tick does not join the back-to-back launch; it launches on a later tick.
- Frame length in ticks = 1 + DATA_W + par_en + 1 + two_stop.
- baud_tick held high continuously gives one clk per bit; this is legal and must work.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (3-bit);
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - DATA_W legal-range constants.
- One natural sub-module: uart_parity_calc (combinational, parametrised by DATA_W; inputs data and par_type, output parity bit). It is shared later with the RX checker.

Test Plan:
- 8N1, 0xA5, LSB_FIRST=1 → tx_out per tick: 0,1,0,1,0,0,1,0,1,1, then idle 1; frame_done after tick 10; busy high for 10 ticks.
- 8E1, 0x03 → parity bit 0, frame 11 ticks. 8O2, 0x07 → parity bit 0, stop 1,1, frame 12 ticks.
- Back-to-back: 0x55 offered, then 0xAA offered while busy → data_ready low until the first word is loaded; second start bit immediately follows the first stop bit with no idle tick; busy never drops between frames.
- rst pulsed low at the 4th data bit of 0xFF → tx_out=1 immediately; data_ready=1; no further frame once rst returns high.
- baud_tick tied high, DATA_W=5, LSB_FIRST=0, 0x11, par_en=0 → line 0,1,0,0,0,1,1 on consecutive clocks.
- par_type toggled mid-frame → parity bit matches the value latched at START.
